// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feed WB_SIZE registered writeback
// slots through a round-robin scan that resumes after the last granted source.
module wb_arbiter #(
  parameter int SRC_NUM    = 6,
  parameter int WB_SIZE    = 4,
  parameter int PREG_WIDTH = 7,
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SRC_NUM-1:0]                   src_valid,
  output logic [SRC_NUM-1:0]                   src_ready,
  input  logic [SRC_NUM-1:0][PREG_WIDTH-1:0]   src_rd,
  input  logic [SRC_NUM-1:0][XLEN-1:0]         src_res,
  output logic [WB_SIZE-1:0]                   wb_en,
  output logic [WB_SIZE-1:0][PREG_WIDTH-1:0]   wb_rd,
  output logic [WB_SIZE-1:0][XLEN-1:0]         wb_res
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SRC_W  = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int GNT_W  = $clog2(WB_SIZE + 1);
  localparam int SLOT_W = (WB_SIZE > 1) ? $clog2(WB_SIZE) : 1;

  logic [PREG_WIDTH-1:0] r_fifo_rd  [SRC_NUM][FIFO_DEPTH];
  logic [XLEN-1:0]       r_fifo_res [SRC_NUM][FIFO_DEPTH];
  logic [CNT_W-1:0]      r_count    [SRC_NUM];
  logic [PTR_W-1:0]      r_head     [SRC_NUM];
  logic [PTR_W-1:0]      r_tail     [SRC_NUM];
  logic [SRC_W-1:0]      r_rr_ptr;

  logic [SRC_NUM-1:0]    w_push;
  logic [SRC_NUM-1:0]    w_grant;
  logic [WB_SIZE-1:0]    w_slot_vld;
  logic [PREG_WIDTH-1:0] w_slot_rd  [WB_SIZE];
  logic [XLEN-1:0]       w_slot_res [WB_SIZE];
  logic [SRC_W-1:0]      w_rr_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  // Ready depends only on the registered count, so a same-cycle pop never raises it.
  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      src_ready[i] = (r_count[i] != CNT_W'(FIFO_DEPTH));
      w_push[i]    = src_valid[i] & src_ready[i];
    end
  end

  // Round-robin scan from r_rr_ptr; the n-th grant lands in slot n.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] sidx;
    logic [GNT_W-1:0] ngnt;
    logic [SRC_W-1:0] last;
    w_grant    = '0;
    w_slot_vld = '0;
    for (int k = 0; k < WB_SIZE; k++) begin
      w_slot_rd[k]  = '0;
      w_slot_res[k] = '0;
    end
    ngnt = '0;
    last = r_rr_ptr;
    sum  = '0;
    sidx = '0;
    for (int j = 0; j < SRC_NUM; j++) begin
      sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(j);
      if (sum >= (SRC_W+1)'(SRC_NUM)) sum = sum - (SRC_W+1)'(SRC_NUM);
      else sum = sum;
      sidx = sum[SRC_W-1:0];
      if ((r_count[sidx] != '0) && (ngnt < GNT_W'(WB_SIZE))) begin
        w_grant[sidx]                  = 1'b1;
        w_slot_vld[ngnt[SLOT_W-1:0]]   = 1'b1;
        w_slot_rd[ngnt[SLOT_W-1:0]]    = r_fifo_rd[sidx][r_head[sidx]];
        w_slot_res[ngnt[SLOT_W-1:0]]   = r_fifo_res[sidx][r_head[sidx]];
        last = sidx;
        ngnt = ngnt + GNT_W'(1);
      end else begin
        ngnt = ngnt;
      end
    end
    if (ngnt == '0) w_rr_next = r_rr_ptr;
    else if (last == SRC_W'(SRC_NUM - 1)) w_rr_next = '0;
    else w_rr_next = last + SRC_W'(1);
  end

  // FIFO push/pop bookkeeping, writeback slot registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SRC_NUM; i++) begin
        r_count[i] <= '0;
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
      end
      r_rr_ptr <= '0;
      wb_en    <= '0;
      wb_rd    <= '0;
      wb_res   <= '0;
    end else begin
      for (int i = 0; i < SRC_NUM; i++) begin
        if (w_push[i]) begin
          r_fifo_rd[i][r_tail[i]]  <= src_rd[i];
          r_fifo_res[i][r_tail[i]] <= src_res[i];
          r_tail[i]                <= ptr_inc(r_tail[i]);
        end
        if (w_grant[i]) r_head[i] <= ptr_inc(r_head[i]);
        if (w_push[i] && !w_grant[i]) r_count[i] <= r_count[i] + CNT_W'(1);
        else if (!w_push[i] && w_grant[i]) r_count[i] <= r_count[i] - CNT_W'(1);
      end
      // Idle slots keep their last rd/res; only the enable drops.
      for (int k = 0; k < WB_SIZE; k++) begin
        wb_en[k] <= w_slot_vld[k];
        if (w_slot_vld[k]) begin
          wb_rd[k]  <= w_slot_rd[k];
          wb_res[k] <= w_slot_res[k];
        end
      end
      r_rr_ptr <= w_rr_next;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
module tb_wb_arbiter;
  localparam int SRC_NUM = 6;
  localparam int WB_SIZE = 4;
  localparam int PW      = 7;
  localparam int XL      = 32;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [SRC_NUM-1:0]           src_valid;
  logic [SRC_NUM-1:0]           src_ready;
  logic [SRC_NUM-1:0][PW-1:0]   src_rd;
  logic [SRC_NUM-1:0][XL-1:0]   src_res;
  logic [WB_SIZE-1:0]           wb_en;
  logic [WB_SIZE-1:0][PW-1:0]   wb_rd;
  logic [WB_SIZE-1:0][XL-1:0]   wb_res;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_res(src_res),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_res(wb_res)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    src_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = '0;
    src_rd = '0;
    src_res = '0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (wb_en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b expected 0000", wb_en); end
    n_checks++;
    if (wb_rd !== '0 || wb_res !== '0) begin n_fail++; $display("FAIL reset_data: got rd=%h res=%h expected 0", wb_rd, wb_res); end
    n_checks++;
    if (src_ready !== 6'h3f) begin n_fail++; $display("FAIL reset_ready: got %b expected 111111", src_ready); end
  endtask

  task automatic test_single();
    do_reset();
    src_valid = 6'b000100;
    src_rd[2] = 7'd5;
    src_res[2] = 32'hDEADBEEF;
    tick();
    src_valid = '0;
    tick();
    n_checks++;
    if (wb_en !== 4'b0001) begin n_fail++; $display("FAIL single_en: got %b expected 0001", wb_en); end
    n_checks++;
    if (wb_rd[0] !== 7'd5 || wb_res[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_data: got rd=%0d res=%h expected rd=5 res=deadbeef", wb_rd[0], wb_res[0]);
    end
    tick();
    n_checks++;
    if (wb_en !== 4'b0000) begin n_fail++; $display("FAIL single_idle: got %b expected 0000", wb_en); end
  endtask

  task automatic test_fairness();
    logic [SRC_NUM-1:0] prev;
    logic [SRC_NUM-1:0] cur;
    do_reset();
    for (int i = 0; i < SRC_NUM; i++) begin
      src_rd[i]  = PW'(i + 1);
      src_res[i] = 32'h100 + 32'(i);
    end
    src_valid = '1;
    tick();
    prev = '1;
    for (int c = 0; c < 6; c++) begin
      tick();
      cur = '0;
      for (int k = 0; k < WB_SIZE; k++) begin
        int e;
        e = (4 * c + k) % SRC_NUM;
        n_checks++;
        if ({wb_en[k], wb_rd[k], wb_res[k]} !== {1'b1, PW'(e + 1), 32'h100 + 32'(e)}) begin
          n_fail++;
          $display("FAIL fair_slot c%0d k%0d: got en=%b rd=%0d res=%h expected en=1 rd=%0d res=%h",
                   c, k, wb_en[k], wb_rd[k], wb_res[k], e + 1, 32'h100 + 32'(e));
        end
        if (wb_en[k] && wb_rd[k] >= 7'd1 && wb_rd[k] <= 7'd6) cur[int'(wb_rd[k]) - 1] = 1'b1;
      end
      n_checks++;
      if ((prev | cur) !== 6'h3f) begin n_fail++; $display("FAIL fair_starve c%0d: got granted=%b expected 111111", c, prev | cur); end
      prev = cur;
    end
    src_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [XL-1:0] q[$];
    logic          acc;
    int            n_push;
    do_reset();
    for (int i = 0; i < SRC_NUM; i++) begin
      src_rd[i]  = PW'(i + 1);
      src_res[i] = 32'h200 + 32'(i);
    end
    src_res[5] = 32'h500;
    src_valid = '1;
    n_push = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 1) begin
        n_checks++;
        if (src_ready[5] !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b expected 1", src_ready[5]); end
      end
      if (c == 2) begin
        n_checks++;
        if (src_ready[5] !== 1'b0) begin n_fail++; $display("FAIL bp_ready2: got %b expected 0", src_ready[5]); end
      end
      acc = src_valid[5] & src_ready[5];
      if (acc) begin q.push_back(src_res[5]); n_push++; end
      tick();
      if (acc) src_res[5] = src_res[5] + 32'd1;
      if (c == 11) src_valid = '0;
      for (int k = 0; k < WB_SIZE; k++) begin
        if (wb_en[k] && wb_rd[k] == 7'd6) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++; $display("FAIL bp_dup: got res=%h expected no further result", wb_res[k]);
          end else begin
            logic [XL-1:0] e;
            e = q.pop_front();
            if (wb_res[k] !== e) begin n_fail++; $display("FAIL bp_order: got res=%h expected %h", wb_res[k], e); end
          end
        end
      end
    end
    n_checks++;
    if (q.size() != 0 || n_push < 6) begin
      n_fail++; $display("FAIL bp_lost: got %0d undelivered of %0d pushed expected 0 undelivered", q.size(), n_push);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    src_valid = 6'b000001;
    src_rd[0] = 7'd0;
    src_res[0] = 32'd7;
    tick();
    src_valid = '0;
    tick();
    n_checks++;
    if (wb_en[0] !== 1'b1 || wb_rd[0] !== 7'd0 || wb_res[0] !== 32'd7) begin
      n_fail++; $display("FAIL rd_zero: got en=%b rd=%0d res=%0d expected en=1 rd=0 res=7", wb_en[0], wb_rd[0], wb_res[0]);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < SRC_NUM; i++) begin
      src_rd[i]  = PW'(i + 1);
      src_res[i] = 32'h300 + 32'(i);
    end
    src_valid = '1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (wb_en !== 4'b0000 || src_ready !== 6'h3f) begin
      n_fail++; $display("FAIL mid_reset: got en=%b ready=%b expected en=0000 ready=111111", wb_en, src_ready);
    end
    rst = 1'b0;
    src_valid = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (wb_en !== 4'b0000) begin n_fail++; $display("FAIL mid_stale c%0d: got en=%b expected 0000", c, wb_en); end
    end
  endtask

  task automatic test_push_pop();
    logic exp_en;
    do_reset();
    src_rd[1] = 7'd9;
    for (int t = 1; t <= 12; t++) begin
      if (t <= 10) begin
        src_valid = 6'b000010;
        src_res[1] = 32'h1000 + 32'(t - 1);
        n_checks++;
        if (src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL pp_ready t%0d: got %b expected 1", t, src_ready[1]); end
      end else begin
        src_valid = '0;
      end
      tick();
      exp_en = (t >= 2 && t <= 11);
      n_checks++;
      if (wb_en !== {3'b000, exp_en}) begin n_fail++; $display("FAIL pp_en t%0d: got %b expected %b", t, wb_en, {3'b000, exp_en}); end
      if (exp_en) begin
        n_checks++;
        if (wb_rd[0] !== 7'd9 || wb_res[0] !== 32'h1000 + 32'(t - 2)) begin
          n_fail++; $display("FAIL pp_data t%0d: got rd=%0d res=%h expected rd=9 res=%h", t, wb_rd[0], wb_res[0], 32'h1000 + 32'(t - 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_rd_zero();
    test_reset_midflight();
    test_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
